run_control_fsm: RTL and testbench

- Parametrised run/stop/step control FSM for the MIC-1 board top. Successor to the single-purpose button FSM.
- Debounces NUM_BUTTONS push-buttons and converts them to one-cycle press pulses.
- Drives a clock-enable and a soft reset into the MIC-1 core, and reports state on LEDs plus a step counter.
- Adds multi-cycle stepping, a CPU-requested halt, a timed soft reset, and fixed button priority.

---
 rtl/run_control_pkg.sv | 28 ++
 rtl/run_control_fsm_debounce_edge.sv | 61 ++++++
 rtl/run_control_fsm.sv | 181 ++++++++++++++++++
 tb/tb_run_control_fsm.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_control_pkg.sv
// Shared types and index constants for the MIC-1 run/stop/step controller.
package run_control_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RUN        = 3'd1,
        ST_STEP       = 3'd2,
        ST_HALTED     = 3'd3,
        ST_RESET_SYNC = 3'd4
    } state_t;

    localparam int BTN_RUN   = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_STEP  = 2;
    localparam int BTN_CLEAR = 3;
    localparam int BTN_RESET = 4;

    localparam int LED_RUN    = 0;
    localparam int LED_IDLE   = 1;
    localparam int LED_STEP   = 2;
    localparam int LED_HALTED = 3;
    localparam int LED_RESET  = 4;
    localparam int LED_CNT0   = 5;
    localparam int LED_W      = 6;

    localparam logic [LED_W-1:0] LED_ILLEGAL = 6'b011111;

endpackage

// File: rtl/run_control_fsm_debounce_edge.sv
// Button conditioner: 2-flop synchroniser, debounce counter and a
// one-cycle press pulse on each accepted rising level.
module debounce_edge
    import run_control_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [1:0]       sync_d;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    // The counter's final step is itself the last required sample,
    // so a full DEBOUNCE_CYCLES run of differing samples flips the level.
    always_comb begin
        sync_d   = {sync_q[0], raw_in};
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q[1];
                press_d  = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign level = stable_q;
    assign press = press_q;

endmodule

// File: rtl/run_control_fsm.sv
// Run/stop/step control FSM for the MIC-1 board: drives the core clock
// enable and soft reset from debounced buttons and a core halt request.
module run_control_fsm
    import run_control_pkg::*;
#(
    parameter int NUM_BUTTONS     = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int STEP_CYCLES     = 1,
    parameter int RESET_CYCLES    = 16,
    parameter int COUNT_W         = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] button,
    input  logic                   halt_req,
    output logic                   cpu_clk_en,
    output logic                   cpu_reset,
    output logic [2:0]             state,
    output logic [COUNT_W-1:0]     step_count,
    output logic [LED_W-1:0]       led
);

    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int RST_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(STEP_CYCLES - 1);
    localparam logic [RST_W-1:0]  RST_LOAD  = RST_W'(RESET_CYCLES - 1);

    logic [NUM_BUTTONS-1:0] press;
    logic [NUM_BUTTONS-1:0] level;
    logic                   unused_bits;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        debounce_edge #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .raw_in(button[i]),
            .level (level[i]),
            .press (press[i])
        );
    end

    // Levels and buttons above index 4 are conditioned but have no function.
    assign unused_bits = ^{level, press};

    state_t             state_q;
    state_t             state_d;
    logic [STEP_W-1:0]  step_cnt_q;
    logic [STEP_W-1:0]  step_cnt_d;
    logic [RST_W-1:0]   rst_cnt_q;
    logic [RST_W-1:0]   rst_cnt_d;
    logic [COUNT_W-1:0] step_count_q;
    logic [COUNT_W-1:0] step_count_d;

    logic go_reset;
    logic go_stop;
    logic go_step;
    logic go_run;
    logic go_clear;
    logic step_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            step_cnt_q   <= '0;
            rst_cnt_q    <= '0;
            step_count_q <= '0;
        end else begin
            state_q      <= state_d;
            step_cnt_q   <= step_cnt_d;
            rst_cnt_q    <= rst_cnt_d;
            step_count_q <= step_count_d;
        end
    end

    // Only the highest-priority control press survives a tie.
    always_comb begin
        go_reset = press[BTN_RESET];
        go_stop  = press[BTN_STOP] & ~go_reset;
        go_step  = press[BTN_STEP] & ~press[BTN_STOP] & ~go_reset;
        go_run   = press[BTN_RUN] & ~press[BTN_STEP]
                 & ~press[BTN_STOP] & ~go_reset;
        go_clear = press[BTN_CLEAR];
    end

    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        rst_cnt_d  = rst_cnt_q;
        step_done  = 1'b0;
        if (go_reset) begin
            state_d   = ST_RESET_SYNC;
            rst_cnt_d = RST_LOAD;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (go_step) begin
                        state_d    = ST_STEP;
                        step_cnt_d = STEP_LOAD;
                    end else if (go_run) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (halt_req) begin
                        state_d = ST_HALTED;
                    end else if (go_stop) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_STEP: begin
                    if (halt_req) begin
                        state_d = ST_HALTED;
                    end else if (go_stop) begin
                        state_d = ST_IDLE;
                    end else if (step_cnt_q == '0) begin
                        state_d   = ST_IDLE;
                        step_done = 1'b1;
                    end else begin
                        step_cnt_d = step_cnt_q - STEP_W'(1);
                    end
                end
                ST_HALTED: begin
                    state_d = ST_HALTED;
                end
                ST_RESET_SYNC: begin
                    if (rst_cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        rst_cnt_d = rst_cnt_q - RST_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        step_count_d = step_count_q;
        if (go_clear) begin
            step_count_d = '0;
        end else if (step_done) begin
            step_count_d = step_count_q + COUNT_W'(1);
        end
    end

    always_comb begin
        cpu_clk_en    = 1'b0;
        cpu_reset     = 1'b0;
        led           = '0;
        led[LED_CNT0] = step_count_q[0];
        case (state_q)
            ST_IDLE: begin
                led[LED_IDLE] = 1'b1;
            end
            ST_RUN: begin
                cpu_clk_en   = 1'b1;
                led[LED_RUN] = 1'b1;
            end
            ST_STEP: begin
                cpu_clk_en    = 1'b1;
                led[LED_STEP] = 1'b1;
            end
            ST_HALTED: begin
                led[LED_HALTED] = 1'b1;
            end
            ST_RESET_SYNC: begin
                cpu_reset      = 1'b1;
                led[LED_RESET] = 1'b1;
            end
            default: begin
                led = LED_ILLEGAL;
            end
        endcase
    end

    assign state      = state_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_run_control_fsm.sv
// Directed bench for run_control_fsm with short debounce/step/reset timers.
module tb_run_control_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] button = '0;
    logic       halt_req = 1'b0;
    logic       cpu_clk_en;
    logic       cpu_reset;
    logic [2:0] state;
    logic [2:0] step_count;
    logic [5:0] led;

    int checks = 0;
    int failures = 0;

    localparam logic [4:0] M_RUN  = 5'b00001;
    localparam logic [4:0] M_STOP = 5'b00010;
    localparam logic [4:0] M_STEP = 5'b00100;
    localparam logic [4:0] M_CLR  = 5'b01000;
    localparam logic [4:0] M_RST  = 5'b10000;

    run_control_fsm #(
        .NUM_BUTTONS    (5),
        .DEBOUNCE_CYCLES(4),
        .STEP_CYCLES    (3),
        .RESET_CYCLES   (5),
        .COUNT_W        (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .button    (button),
        .halt_req  (halt_req),
        .cpu_clk_en(cpu_clk_en),
        .cpu_reset (cpu_reset),
        .state     (state),
        .step_count(step_count),
        .led       (led)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (8) tick();
    endtask

    // Leaves the press pulse live; the next tick shows the new state.
    task automatic press(input logic [4:0] m);
        button = button | m;
        repeat (6) tick();
        button = button & ~m;
    endtask

    task automatic do_step();
        int n;
        press(M_STEP);
        tick();
        n = 0;
        while (cpu_clk_en === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        settle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (state !== 3'd0) begin
            failures++;
            $display("FAIL reset_state got=%0d exp=0", state);
        end
        checks++;
        if (cpu_clk_en !== 1'b0 || cpu_reset !== 1'b0) begin
            failures++;
            $display("FAIL reset_outs got=%b%b exp=00", cpu_clk_en, cpu_reset);
        end
        checks++;
        if (step_count !== 3'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=0", step_count);
        end
        checks++;
        if (led !== 6'b000010) begin
            failures++;
            $display("FAIL reset_led got=%b exp=000010", led);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_bounce_run();
        int n;
        for (int i = 0; i < 10; i++) begin
            button[0] = (i % 2 == 0);
            tick();
        end
        checks++;
        if (state !== 3'd0) begin
            failures++;
            $display("FAIL bounce_idle got=%0d exp=0", state);
        end
        button[0] = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (state !== 3'd1 && n < 20);
        checks++;
        if (n !== 7) begin
            failures++;
            $display("FAIL bounce_latency got=%0d exp=7", n);
        end
        checks++;
        if (cpu_clk_en !== 1'b1 || led !== 6'b000001) begin
            failures++;
            $display("FAIL run_outs got=%b/%b exp=1/000001", cpu_clk_en, led);
        end
        button[0] = 1'b0;
        settle();
        press(M_STOP);
        tick();
        checks++;
        if (state !== 3'd0 || cpu_clk_en !== 1'b0) begin
            failures++;
            $display("FAIL stop_run got=%0d/%b exp=0/0", state, cpu_clk_en);
        end
        settle();
    endtask

    task automatic test_step();
        int n;
        logic [5:0] exp_led;
        for (int k = 1; k <= 4; k++) begin
            press(M_STEP);
            tick();
            exp_led = ((k - 1) % 2 == 1) ? 6'b100100 : 6'b000100;
            checks++;
            if (state !== 3'd2 || led !== exp_led) begin
                failures++;
                $display("FAIL step_enter got=%0d/%b exp=2/%b", state, led, exp_led);
            end
            n = 0;
            while (cpu_clk_en === 1'b1 && n < 20) begin
                n++;
                tick();
            end
            checks++;
            if (n !== 3) begin
                failures++;
                $display("FAIL step_len got=%0d exp=3", n);
            end
            checks++;
            if (state !== 3'd0 || step_count !== 3'(k)) begin
                failures++;
                $display("FAIL step_done got=%0d/%0d exp=0/%0d", state, step_count, k);
            end
            settle();
        end
    endtask

    task automatic test_halt();
        int n;
        press(M_RUN);
        tick();
        checks++;
        if (state !== 3'd1) begin
            failures++;
            $display("FAIL halt_pre_run got=%0d exp=1", state);
        end
        settle();
        press(M_STOP);
        halt_req = 1'b1;
        tick();
        checks++;
        if (state !== 3'd3 || cpu_clk_en !== 1'b0 || led !== 6'b001000) begin
            failures++;
            $display("FAIL halt_vs_stop got=%0d/%b/%b exp=3/0/001000", state, cpu_clk_en, led);
        end
        settle();
        press(M_RUN);
        tick();
        checks++;
        if (state !== 3'd3) begin
            failures++;
            $display("FAIL halt_ign_run got=%0d exp=3", state);
        end
        settle();
        press(M_STEP);
        tick();
        checks++;
        if (state !== 3'd3) begin
            failures++;
            $display("FAIL halt_ign_step got=%0d exp=3", state);
        end
        settle();
        press(M_RST);
        tick();
        halt_req = 1'b0;
        checks++;
        if (state !== 3'd4 || led !== 6'b010000) begin
            failures++;
            $display("FAIL rsync_enter got=%0d/%b exp=4/010000", state, led);
        end
        n = 0;
        while (cpu_reset === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 5) begin
            failures++;
            $display("FAIL rsync_len got=%0d exp=5", n);
        end
        checks++;
        if (state !== 3'd0) begin
            failures++;
            $display("FAIL rsync_exit got=%0d exp=0", state);
        end
        settle();
    endtask

    task automatic test_multi_press();
        press(M_RUN);
        tick();
        settle();
        press(M_STOP | M_STEP | M_RST);
        tick();
        checks++;
        if (state !== 3'd4 || cpu_reset !== 1'b1) begin
            failures++;
            $display("FAIL multi_prio got=%0d/%b exp=4/1", state, cpu_reset);
        end
        settle();
        checks++;
        if (state !== 3'd0) begin
            failures++;
            $display("FAIL multi_exit got=%0d exp=0", state);
        end
    endtask

    task automatic test_stop_in_step();
        button = button | M_STEP;
        tick();
        button = button | M_STOP;
        repeat (5) tick();
        button = button & ~M_STEP;
        tick();
        checks++;
        if (state !== 3'd2) begin
            failures++;
            $display("FAIL sis_enter got=%0d exp=2", state);
        end
        tick();
        checks++;
        if (state !== 3'd0 || cpu_clk_en !== 1'b0 || step_count !== 3'd4) begin
            failures++;
            $display("FAIL sis_abort got=%0d/%b/%0d exp=0/0/4", state, cpu_clk_en, step_count);
        end
        button = button & ~M_STOP;
        settle();
    endtask

    task automatic test_clear();
        press(M_RUN);
        tick();
        settle();
        press(M_CLR);
        tick();
        checks++;
        if (step_count !== 3'd0 || state !== 3'd1 || led !== 6'b000001) begin
            failures++;
            $display("FAIL clear got=%0d/%0d/%b exp=0/1/000001", step_count, state, led);
        end
        settle();
        press(M_STOP);
        tick();
        settle();
    endtask

    task automatic test_wrap();
        repeat (7) do_step();
        checks++;
        if (step_count !== 3'd7 || led !== 6'b100010) begin
            failures++;
            $display("FAIL wrap_pre got=%0d/%b exp=7/100010", step_count, led);
        end
        do_step();
        checks++;
        if (step_count !== 3'd0 || led !== 6'b000010) begin
            failures++;
            $display("FAIL wrap got=%0d/%b exp=0/000010", step_count, led);
        end
    endtask

    task automatic test_clear_wins();
        do_step();
        button = button | M_STEP;
        repeat (3) tick();
        button = button | M_CLR;
        repeat (3) tick();
        button = button & ~M_STEP;
        repeat (3) tick();
        checks++;
        if (state !== 3'd2 || step_count !== 3'd1) begin
            failures++;
            $display("FAIL cw_last got=%0d/%0d exp=2/1", state, step_count);
        end
        tick();
        checks++;
        if (state !== 3'd0 || step_count !== 3'd0) begin
            failures++;
            $display("FAIL clear_wins got=%0d/%0d exp=0/0", state, step_count);
        end
        button = button & ~M_CLR;
        settle();
    endtask

    task automatic test_async_abort();
        do_step();
        press(M_RST);
        tick();
        tick();
        checks++;
        if (state !== 3'd4) begin
            failures++;
            $display("FAIL abort_pre got=%0d exp=4", state);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (state !== 3'd0 || cpu_reset !== 1'b0 || step_count !== 3'd0 || led !== 6'b000010) begin
            failures++;
            $display("FAIL abort_rsync got=%0d/%b/%0d/%b exp=0/0/0/000010", state, cpu_reset, step_count, led);
        end
        reset = 1'b0;
        tick();
        settle();
        do_step();
        press(M_STEP);
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (state !== 3'd0 || cpu_clk_en !== 1'b0 || step_count !== 3'd0) begin
            failures++;
            $display("FAIL abort_step got=%0d/%b/%0d exp=0/0/0", state, cpu_clk_en, step_count);
        end
        reset = 1'b0;
        tick();
        settle();
    endtask

    initial begin
        test_reset();
        test_bounce_run();
        test_step();
        test_halt();
        test_multi_press();
        test_stop_in_step();
        test_clear();
        test_wrap();
        test_clear_wins();
        test_async_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
